// File: rtl/clk_divider_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_divider_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DIV_RST_DEFAULT = 2;
  localparam int TICK_CNT_W      = 16;

endpackage

// File: rtl/clk_divider.sv
// Programmable integer clock divider with a tick pulse and a divided clock level.
// Optional tick counter output enabled by defining CLK_DIVIDER_TICK_CNT_EN.
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DIV_RST = DIV_RST_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_ack,
  output logic             busy,
  output logic             tick,
  output logic             div_clk
`ifdef CLK_DIVIDER_TICK_CNT_EN
  ,
  output logic [TICK_CNT_W-1:0] tick_cnt
`endif
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] div_act, div_next;
  logic [CNT_W-1:0] shadow, shadow_next;
  logic [CNT_W-1:0] shadow_eff;
  logic [CNT_W-1:0] half_next;
  logic             busy_next;
  logic             ack_next;
  logic             wrap;
  logic             apply;
  logic             tick_next;
  logic             div_clk_next;

  // A zero divisor is treated as divide-by-one.
  assign shadow_eff = (shadow == '0) ? ONE : shadow;

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    div_next    = div_act;
    shadow_next = shadow;
    busy_next   = busy;
    ack_next    = 1'b0;
    wrap        = (state == RUN) && (cnt == div_act - ONE);

    if (state == IDLE) begin
      cnt_next = '0;
      if (en) begin
        state_next = RUN;
      end
    end else begin
      if (!en) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else if (wrap) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt + ONE;
      end
    end

    // Pending divisor goes live only where a period starts fresh.
    apply = busy && ((state == IDLE) || !en || wrap);
    if (apply) begin
      div_next  = shadow_eff;
      busy_next = 1'b0;
      ack_next  = 1'b1;
    end else if (div_load && !busy) begin
      shadow_next = div_val;
      busy_next   = 1'b1;
    end

    // Outputs are computed from next-cycle state so they come straight from flops.
    half_next    = (div_next >> 1) + {{(CNT_W-1){1'b0}}, div_next[0]};
    tick_next    = (state_next == RUN) && (cnt_next == div_next - ONE);
    div_clk_next = (state_next == RUN) && (cnt_next < half_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      div_act <= DIV_RST_V;
      shadow  <= '0;
      busy    <= 1'b0;
      div_ack <= 1'b0;
      tick    <= 1'b0;
      div_clk <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      div_act <= div_next;
      shadow  <= shadow_next;
      busy    <= busy_next;
      div_ack <= ack_next;
      tick    <= tick_next;
      div_clk <= div_clk_next;
    end
  end

`ifdef CLK_DIVIDER_TICK_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + TICK_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider: directed scenarios plus randomized traffic
// against a period-level reference model.
module tb_clk_divider;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       en       = 1'b0;
  logic       div_load = 1'b0;
  logic [7:0] div_val  = 8'd0;
  logic       div_ack, busy, tick, div_clk;
`ifdef CLK_DIVIDER_TICK_CNT_EN
  logic [15:0] tick_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clk_divider #(.CNT_W(8), .DIV_RST(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_load (div_load),
    .div_val  (div_val),
    .div_ack  (div_ack),
    .busy     (busy),
    .tick     (tick),
    .div_clk  (div_clk)
`ifdef CLK_DIVIDER_TICK_CNT_EN
    ,
    .tick_cnt (tick_cnt)
`endif
  );

  // Reference model: position within the current period, active and requested divisor.
  bit          m_run = 0, m_pend = 0, m_ack = 0, m_eop, m_apply;
  int          m_pos = 0, m_n = 2, m_shadow = 0;
  int unsigned m_tcnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_pend = 0; m_ack = 0; m_pos = 0; m_n = 2; m_shadow = 0; m_tcnt = 0;
    end else begin
      m_eop   = m_run && (m_pos == m_n - 1);
      m_apply = m_pend && (!m_run || !en || m_eop);
      if (m_eop) m_tcnt = (m_tcnt + 1) % 65536;
      m_ack = m_apply;
      if (m_run && en) m_pos = m_eop ? 0 : m_pos + 1;
      else m_pos = 0;
      m_run = en;
      if (m_apply) begin
        m_n    = (m_shadow == 0) ? 1 : m_shadow;
        m_pend = 0;
      end else if (div_load && !m_pend) begin
        m_shadow = int'(div_val);
        m_pend   = 1;
      end
    end
  end

  function automatic logic [3:0] expv();
    return {m_run && (m_pos == m_n - 1), m_run && (2 * m_pos < m_n), m_pend, m_ack};
  endfunction

  function automatic logic [3:0] obsv();
    return {tick, div_clk, busy, div_ack};
  endfunction

  task automatic step(input logic e, input logic l, input logic [7:0] v);
    en = e; div_load = l; div_val = v;
    @(negedge clk);
  endtask

  task automatic wait_ack(input string tag);
    int k;
    for (k = 0; k < 600 && div_ack !== 1'b1; k++) step(en, 1'b0, 8'd0);
    vectors++;
    if (div_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ack_timeout: div_ack=%b required 1", tag, div_ack);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'd5);
      vectors++;
      if (obsv() !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_outputs: tick/div_clk/busy/ack=%b required 0000", obsv());
      end
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'd0);
    vectors++;
    if (obsv() !== expv()) begin
      miscompares++;
      $display("FAIL reset_release: got %b required %b", obsv(), expv());
    end
  endtask

  task automatic test_default_n2();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 8'd0);
      vectors++;
      if ({tick, div_clk} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("FAIL n2_pattern cyc %0d: tick/div_clk=%b%b required %s", i, tick, div_clk,
                 (i % 2 == 0) ? "01" : "10");
      end
      vectors++;
      if (obsv() !== expv()) begin
        miscompares++;
        $display("FAIL n2_model cyc %0d: got %b required %b", i, obsv(), expv());
      end
    end
  endtask

  task automatic test_idle_load5();
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 8'd5);
    vectors++;
    if ({busy, div_ack} !== 2'b10) begin
      miscompares++;
      $display("FAIL idle_load_cyc1: busy/ack=%b%b required 10", busy, div_ack);
    end
    step(1'b0, 1'b0, 8'd0);
    vectors++;
    if ({busy, div_ack} !== 2'b01) begin
      miscompares++;
      $display("FAIL idle_load_cyc2: busy/ack=%b%b required 01", busy, div_ack);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 8'd0);
      vectors++;
      if ({tick, div_clk} !== {1'((i % 5) == 4), 1'((i % 5) < 3)}) begin
        miscompares++;
        $display("FAIL n5_pattern cyc %0d: tick/div_clk=%b%b required %b%b", i, tick, div_clk,
                 1'((i % 5) == 4), 1'((i % 5) < 3));
      end
    end
  endtask

  task automatic test_runtime_load();
    int last = -1;
    step(1'b1, 1'b1, 8'd4);
    wait_ack("n4");
    for (int k = 0; k < 20 && m_pos != 1; k++) step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 8'd3);
    step(1'b1, 1'b1, 8'd7);
    vectors++;
    if ({busy, div_ack} !== 2'b10) begin
      miscompares++;
      $display("FAIL rt_busy_held: busy/ack=%b%b required 10", busy, div_ack);
    end
    step(1'b1, 1'b0, 8'd0);
    vectors++;
    if ({busy, div_ack, tick} !== 3'b010) begin
      miscompares++;
      $display("FAIL rt_ack_at_wrap: busy/ack/tick=%b%b%b required 010", busy, div_ack, tick);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 8'd0);
      if (tick === 1'b1) begin
        if (last >= 0) begin
          vectors++;
          if (i - last != 3) begin
            miscompares++;
            $display("FAIL rt_period: tick gap=%0d required 3", i - last);
          end
        end
        last = i;
      end
      vectors++;
      if (obsv() !== expv()) begin
        miscompares++;
        $display("FAIL rt_model cyc %0d: got %b required %b", i, obsv(), expv());
      end
    end
  endtask

  task automatic test_n_one();
    for (int j = 0; j < 2; j++) begin
      step(1'b1, 1'b1, 8'(j));
      wait_ack("n1");
      for (int i = 0; i < 6; i++) begin
        step(1'b1, 1'b0, 8'd0);
        vectors++;
        if ({tick, div_clk} !== 2'b11) begin
          miscompares++;
          $display("FAIL n1_val%0d cyc %0d: tick/div_clk=%b%b required 11", j, i, tick, div_clk);
        end
      end
    end
  endtask

  task automatic test_abort();
    step(1'b1, 1'b1, 8'd6);
    wait_ack("n6");
    for (int k = 0; k < 20 && m_pos != 2; k++) step(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'd0);
      vectors++;
      if ({tick, div_clk} !== 2'b00) begin
        miscompares++;
        $display("FAIL abort_idle cyc %0d: tick/div_clk=%b%b required 00", i, tick, div_clk);
      end
    end
  endtask

  task automatic test_reset_pending();
    int last = -1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 8'd9);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstp_busy_set: busy=%b required 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obsv() !== 4'b0000) begin
      miscompares++;
      $display("FAIL rstp_async: tick/div_clk/busy/ack=%b required 0000", obsv());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, 8'd0);
      if (tick === 1'b1) begin
        if (last >= 0) begin
          vectors++;
          if (i - last != 2) begin
            miscompares++;
            $display("FAIL rstp_divisor: tick gap=%0d required 2", i - last);
          end
        end
        last = i;
      end
    end
  endtask

`ifdef CLK_DIVIDER_TICK_CNT_EN
  task automatic test_tick_cnt();
    int seen = 0;
    rst_n = 1'b0;
    step(1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 60 && seen < 10; k++) begin
      step(1'b1, 1'b0, 8'd0);
      if (tick === 1'b1) seen++;
    end
    step(1'b0, 1'b0, 8'd0);
    vectors++;
    if (tick_cnt !== 16'd10) begin
      miscompares++;
      $display("FAIL tick_cnt_10: tick_cnt=%0d required 10", tick_cnt);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'd0);
    vectors++;
    if (tick_cnt !== 16'd10) begin
      miscompares++;
      $display("FAIL tick_cnt_hold: tick_cnt=%0d required 10", tick_cnt);
    end
  endtask
`endif

  task automatic test_random();
    logic       e, l;
    logic [7:0] v;
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom_range(0, 24) != 0);
      l = ($urandom_range(0, 5) == 0);
      v = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      step(e, l, v);
      vectors++;
      if (obsv() !== expv()) begin
        miscompares++;
        $display("FAIL random cyc %0d: tick/div_clk/busy/ack=%b required %b", i, obsv(), expv());
      end
`ifdef CLK_DIVIDER_TICK_CNT_EN
      vectors++;
      if (tick_cnt !== 16'(m_tcnt)) begin
        miscompares++;
        $display("FAIL random_tick_cnt cyc %0d: tick_cnt=%0d required %0d", i, tick_cnt, m_tcnt);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_default_n2();
    test_idle_load5();
    test_runtime_load();
    test_n_one();
    test_abort();
    test_reset_pending();
`ifdef CLK_DIVIDER_TICK_CNT_EN
    test_tick_cnt();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
